// File: rtl/scratch_defs.sv
// Shared definitions for the IF scratchpad write side: FSM encoding and
// the address-width derivation used by every module of this block.
package scratch_defs;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // A 2-entry scratchpad still needs one address bit.
  function automatic int addr_len(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/wrap_inc.sv
// Modulo-DEPTH pointer increment; DEPTH need not be a power of two.
module wrap_inc #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic [W-1:0] ptr,
  output logic [W-1:0] ptr_inc
);

  assign ptr_inc = (ptr == W'(DEPTH - 1)) ? '0 : ptr + W'(1);

endmodule

// File: rtl/if_write_addr_gen.sv
// IF scratchpad write-address generator: row-oriented fill FSM plus the
// pointer datapath that publishes write/start/end positions to the read side.
import scratch_defs::*;

module if_write_addr_gen_controller (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic accept,
  input  logic in_last,
  input  logic row_release,
  output logic fill,
  output logic wait_rel,
  output logic busy
);

  state_t state_q, state_d;
  logic   fill_q, fill_d, wait_q, wait_d, busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start)              state_d = FILL;
        FILL:     if (accept && in_last)  state_d = WAIT_REL;
        WAIT_REL: if (row_release)        state_d = FILL;
        default:                          state_d = IDLE;
      endcase
    end
    fill_d = (state_d == FILL);
    wait_d = (state_d == WAIT_REL);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= 1'b0;
      wait_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
    end
  end

  assign fill     = fill_q;
  assign wait_rel = wait_q;
  assign busy     = busy_q;

endmodule

module if_write_addr_gen_datapath #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fill,
  input  logic             wait_rel,
  input  logic             stall_pipeline,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             row_release,
  output logic             in_ready,
  output logic             accept,
  output logic             sc_wen,
  output logic [AW-1:0]    sc_waddr,
  output logic [WIDTH-1:0] sc_wdata,
  output logic [AW-1:0]    IF_waddr,
  output logic [AW-1:0]    IF_start_pos,
  output logic [AW-1:0]    IF_end_pos,
  output logic             IF_end_valid,
  output logic             full
);

  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d, start_pos_q, start_pos_d, end_pos_q, end_pos_d;
  logic [CW-1:0] count_q, count_d;
  logic          end_valid_q, end_valid_d;
  logic [AW-1:0] wptr_inc, end_inc, last_slot;
  logic          rel;

  wrap_inc #(.DEPTH(DEPTH), .W(AW)) u_wptr_inc (.ptr(wptr_q),    .ptr_inc(wptr_inc));
  wrap_inc #(.DEPTH(DEPTH), .W(AW)) u_end_inc  (.ptr(end_pos_q), .ptr_inc(end_inc));

  // Gating in_ready with clear keeps the handshake honest: a beat offered
  // during an abort is neither written nor reported as taken.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    in_ready  = fill & ~full & ~stall_pipeline & ~clear;
    accept    = in_valid & in_ready;
    rel       = wait_rel & row_release & ~clear;
    last_slot = (start_pos_q == '0) ? AW'(DEPTH - 1) : start_pos_q - AW'(1);

    wptr_d      = wptr_q;
    count_d     = count_q;
    start_pos_d = start_pos_q;
    end_pos_d   = end_pos_q;
    end_valid_d = end_valid_q;

    if (clear) begin
      wptr_d      = '0;
      count_d     = '0;
      start_pos_d = '0;
      end_pos_d   = '0;
      end_valid_d = 1'b0;
    end else begin
      if (accept) begin
        wptr_d  = wptr_inc;
        count_d = count_q + CW'(1);
        if (in_last) begin
          end_pos_d   = wptr_q;
          end_valid_d = 1'b1;
        end
      end
      if (rel) begin
        start_pos_d = end_inc;
        count_d     = '0;
        end_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      count_q     <= '0;
      start_pos_q <= '0;
      end_pos_q   <= '0;
      end_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      start_pos_q <= start_pos_d;
      end_pos_q   <= end_pos_d;
      end_valid_q <= end_valid_d;
    end
  end

  // When full, pointing at the last written slot puts the reader's
  // distance at DEPTH-1 instead of aliasing to an empty buffer.
  assign IF_waddr     = full ? last_slot : wptr_q;
  assign sc_wen       = accept;
  assign sc_waddr     = wptr_q;
  assign sc_wdata     = in_data;
  assign IF_start_pos = start_pos_q;
  assign IF_end_pos   = end_pos_q;
  assign IF_end_valid = end_valid_q;

endmodule

module if_write_addr_gen #(
  parameter int IF_SCRATCH_DEPTH = 8,
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int IF_ADDR_LEN      = addr_len(IF_SCRATCH_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        stall_pipeline,
  input  logic                        in_valid,
  input  logic [IF_SCRATCH_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic                        row_release,
  output logic                        sc_wen,
  output logic [IF_ADDR_LEN-1:0]      sc_waddr,
  output logic [IF_SCRATCH_WIDTH-1:0] sc_wdata,
  output logic [IF_ADDR_LEN-1:0]      IF_waddr,
  output logic [IF_ADDR_LEN-1:0]      IF_start_pos,
  output logic [IF_ADDR_LEN-1:0]      IF_end_pos,
  output logic                        IF_end_valid,
  output logic                        full,
  output logic                        busy
);

  logic fill, wait_rel, accept;

  if_write_addr_gen_controller u_ctrl (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .accept(accept), .in_last(in_last), .row_release(row_release),
    .fill(fill), .wait_rel(wait_rel), .busy(busy)
  );

  if_write_addr_gen_datapath #(
    .DEPTH(IF_SCRATCH_DEPTH), .WIDTH(IF_SCRATCH_WIDTH), .AW(IF_ADDR_LEN)
  ) u_dp (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fill(fill), .wait_rel(wait_rel),
    .stall_pipeline(stall_pipeline), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .row_release(row_release), .in_ready(in_ready),
    .accept(accept), .sc_wen(sc_wen), .sc_waddr(sc_waddr), .sc_wdata(sc_wdata),
    .IF_waddr(IF_waddr), .IF_start_pos(IF_start_pos), .IF_end_pos(IF_end_pos),
    .IF_end_valid(IF_end_valid), .full(full)
  );

endmodule

// File: tb/tb_if_write_addr_gen.sv
// Scoreboard bench for if_write_addr_gen: directed rows, expected writes
// queued at issue time and matched by an independent write monitor.
module tb_if_write_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, clear, stall_pipeline, in_valid, in_last, row_release;
  logic [15:0] in_data;
  logic        in_ready, sc_wen, IF_end_valid, full, busy;
  logic [2:0]  sc_waddr, IF_waddr, IF_start_pos, IF_end_pos;
  logic [15:0] sc_wdata;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];

  if_write_addr_gen #(.IF_SCRATCH_DEPTH(8), .IF_SCRATCH_WIDTH(16), .IF_ADDR_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .stall_pipeline(stall_pipeline), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .row_release(row_release),
    .sc_wen(sc_wen), .sc_waddr(sc_waddr), .sc_wdata(sc_wdata),
    .IF_waddr(IF_waddr), .IF_start_pos(IF_start_pos), .IF_end_pos(IF_end_pos),
    .IF_end_valid(IF_end_valid), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the oldest queued one.
  initial begin
    forever begin
      @(negedge clk);
      if (sc_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", sc_waddr, sc_wdata);
        end else begin
          chk("write", {13'd0, sc_waddr, sc_wdata}, {13'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic beat(input logic [15:0] d, input logic l, input logic [2:0] a);
    bit ok = 0;
    exp_q.push_back({a, d});
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; tick(); break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL beat_timeout: got no accept expected accept at addr %0d", a);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_release();
    row_release = 1'b1; tick(); row_release = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; clear = 0; stall_pipeline = 0;
    in_valid = 0; in_last = 0; row_release = 0; in_data = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full_endv_wen", {full, IF_end_valid, sc_wen}, 0);
    chk("rst_ptrs", {IF_waddr, IF_start_pos, IF_end_pos}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 0);

    // Basic row: 0..4
    pulse_start();
    chk("fill_busy", busy, 1);
    chk("fill_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) beat(16'hA000 + 16'(i), i == 4, 3'(i));
    chk("basic_end_valid", IF_end_valid, 1);
    chk("basic_end_pos", IF_end_pos, 4);
    chk("basic_waddr", IF_waddr, 5);
    chk("basic_in_ready_low", in_ready, 0);
    row_release = 1'b1; tick(); row_release = 1'b0;
    chk("rel_start_pos", IF_start_pos, 5);
    chk("rel_end_valid", IF_end_valid, 0);
    chk("rel_in_ready", in_ready, 1);

    // Wrapped row: 5,6,7,0
    beat(16'hB005, 0, 5); beat(16'hB006, 0, 6); beat(16'hB007, 0, 7); beat(16'hB000, 1, 0);
    chk("wrap_end_pos", IF_end_pos, 0);
    chk("wrap_waddr", IF_waddr, 1);
    pulse_release();
    chk("wrap_start_pos", IF_start_pos, 1);

    // Stall mid-row at addr 3
    beat(16'hC001, 0, 1); beat(16'hC002, 0, 2);
    exp_q.push_back({3'd3, 16'hC003});
    in_valid = 1'b1; in_data = 16'hC003; stall_pipeline = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wen", sc_wen, 0);
      chk("stall_waddr", IF_waddr, 3);
    end
    tick();
    stall_pipeline = 1'b0;
    @(negedge clk);
    chk("resume_wen", sc_wen, 1);
    tick();
    in_valid = 1'b0;
    beat(16'hC004, 0, 4); beat(16'hC005, 1, 5);
    chk("stall_end_pos", IF_end_pos, 5);
    chk("stall_waddr_after", IF_waddr, 6);
    pulse_release();
    chk("stall_start_pos", IF_start_pos, 6);

    // Abort with clear at wptr=3
    beat(16'hD006, 0, 6); beat(16'hD007, 0, 7); beat(16'hD000, 0, 0);
    beat(16'hD001, 0, 1); beat(16'hD002, 0, 2);
    chk("pre_clear_waddr", IF_waddr, 3);
    in_valid = 1'b1; in_data = 16'hDEAD; clear = 1'b1;
    @(negedge clk);
    chk("clear_wen", sc_wen, 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_busy", busy, 0);
    chk("clear_ptrs", {IF_waddr, IF_start_pos, IF_end_pos, IF_end_valid, full}, 0);

    // Full row from 0, then a held 9th beat
    pulse_start();
    for (int i = 0; i < 8; i++) beat(16'hE000 + 16'(i), 0, 3'(i));
    chk("full_flag", full, 1);
    chk("full_waddr", IF_waddr, 7);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 16'hE008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ninth_wen", sc_wen, 0);
    end
    tick();
    in_valid = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("full_clear", {full, busy}, 0);

    // Async reset mid-row at wptr=3
    pulse_start();
    beat(16'hF000, 0, 0); beat(16'hF001, 0, 1); beat(16'hF002, 0, 2);
    in_valid = 1'b1; in_data = 16'hF003;
    rst_n = 1'b0;
    #2;
    chk("arst_busy", busy, 0);
    chk("arst_wen_ready", {sc_wen, in_ready}, 0);
    chk("arst_ptrs", {IF_waddr, IF_start_pos, IF_end_pos, IF_end_valid, full}, 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("arst_idle", {busy, in_ready, IF_waddr}, 0);

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
